// File: rtl/cache_writeback_ctrl.sv
// Eviction write-back sequencer: reads a victim block word by word from the data array
// and issues one held memory write per word, lowest address first.
module cache_writeback_ctrl #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned WORDS  = 8,
    parameter int unsigned OFF_W  = 3,
    parameter int unsigned BLK_W  = ADDR_W - OFF_W - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [BLK_W-1:0]  i_blk_addr,
    output logic              o_cache_rd_en,
    output logic [OFF_W-1:0]  o_cache_word_sel,
    input  logic [DATA_W-1:0] i_cache_rdata,
    output logic              o_mem_wr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ready,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    localparam logic [OFF_W-1:0] LastIdx = OFF_W'(WORDS - 1);

    state_e             r_state, w_state_nxt;
    logic [OFF_W-1:0]   r_idx, w_idx_nxt;
    logic [BLK_W-1:0]   r_blk, w_blk_nxt;
    logic [DATA_W-1:0]  r_wdata, w_wdata_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_blk   <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_blk   <= w_blk_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_blk_nxt   = r_blk;
        w_wdata_nxt = r_wdata;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_blk_nxt   = i_blk_addr;
                    w_idx_nxt   = '0;
                    w_state_nxt = StRd;
                end
            end
            StRd: begin
                // Array data for r_idx is valid at the edge that leaves RD.
                w_wdata_nxt = i_cache_rdata;
                w_state_nxt = StWr;
            end
            StWr: begin
                if (i_mem_ready) begin
                    if (r_idx == LastIdx) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_state_nxt = StRd;
                    end
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign o_cache_rd_en    = (r_state == StRd);
    assign o_mem_wr         = (r_state == StWr);
    assign o_done           = (r_state == StDone);
    assign o_busy           = (r_state != StIdle);
    assign o_cache_word_sel = r_idx;
    assign o_mem_addr       = {r_blk, r_idx, 1'b0};
    assign o_mem_wdata      = r_wdata;

endmodule

// File: tb/tb_cache_writeback_ctrl.sv
// Self-checking bench for cache_writeback_ctrl: table-driven evictions, hand-written
// corner sequences and randomized backpressure against a per-block write list model.
module tb_cache_writeback_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] blk_addr;
    logic        cache_rd_en;
    logic [2:0]  cache_word_sel;
    logic [15:0] cache_rdata;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic        busy;
    logic        done;

    logic [15:0] arr [8];
    int          nvec = 0;
    int          nerr = 0;

    cache_writeback_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (start),
        .i_blk_addr       (blk_addr),
        .o_cache_rd_en    (cache_rd_en),
        .o_cache_word_sel (cache_word_sel),
        .i_cache_rdata    (cache_rdata),
        .o_mem_wr         (mem_wr),
        .o_mem_addr       (mem_addr),
        .o_mem_wdata      (mem_wdata),
        .i_mem_ready      (mem_ready),
        .o_busy           (busy),
        .o_done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model: word data presented while the read strobe is up.
    assign cache_rdata = cache_rd_en ? arr[cache_word_sel] : 16'hDEAD;

    typedef struct {
        logic [11:0] blk;
        int          stall_word;
        int          stall_len;
        int          exp_done;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one eviction from an IDLE cycle; returns in the first IDLE cycle after done.
    task automatic run_evict(input logic [11:0] blk, input int sw, input int sl,
                             input bit rnd, input bit inj, input int exp_done);
        int          rel, left, rstalls, got_n, ndone, done_rel, cur;
        logic [15:0] ea;
        for (int i = 0; i < 8; i++) arr[i] = rnd ? 16'($urandom) : 16'h1000 + 16'(i);
        got_n = 0; left = sl; rstalls = 0; ndone = 0; done_rel = 0;
        start = 1'b1;
        blk_addr = blk;
        step();
        start = 1'b0;
        blk_addr = 12'($urandom);
        rel = 1;
        while (ndone == 0 && rel <= 200) begin
            cur = got_n;
            chk("busy_active", 32'(busy), 32'd1);
            chk("one_strobe", 32'(cache_rd_en) + 32'(mem_wr) + 32'(done), 32'd1);
            if (cache_rd_en) chk("word_sel", 32'(cache_word_sel), 32'(got_n));
            if (mem_wr && got_n >= 8) chk("extra_write", 32'(mem_wr), 32'd0);
            if (mem_wr && got_n < 8) begin
                ea = {blk, 4'b0000} + 16'(2 * got_n);
                chk("mem_addr", 32'(mem_addr), 32'(ea));
                chk("mem_wdata", 32'(mem_wdata), 32'(arr[got_n]));
                if (got_n == sw && left > 0) begin
                    mem_ready = 1'b0;
                    left--;
                end else begin
                    mem_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                    if (!mem_ready) rstalls++;
                end
                if (mem_ready) got_n++;
            end else begin
                mem_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (done) begin
                ndone = 1;
                done_rel = rel;
                chk("writes_at_done", 32'(got_n), 32'd8);
            end
            start = inj && ((mem_wr && cur == 3) || done);
            if (inj) blk_addr = 12'h123;
            step();
            rel++;
        end
        start = 1'b0;
        chk("done_seen", 32'(ndone), 32'd1);
        chk("done_cycle", 32'(done_rel), 32'(exp_done + rstalls));
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_pulse_width", 32'(done), 32'd0);
        chk("idle_strobes", 32'(mem_wr) + 32'(cache_rd_en), 32'd0);
    endtask

    initial begin
        vec_t tbl[5];
        tbl[0] = '{blk: 12'hABC, stall_word: -1, stall_len: 0, exp_done: 17};
        tbl[1] = '{blk: 12'hABC, stall_word: 2,  stall_len: 3, exp_done: 20};
        tbl[2] = '{blk: 12'hFFF, stall_word: -1, stall_len: 0, exp_done: 17};
        tbl[3] = '{blk: 12'h000, stall_word: 7,  stall_len: 1, exp_done: 18};
        tbl[4] = '{blk: 12'h555, stall_word: 0,  stall_len: 2, exp_done: 19};

        rst_n = 1'b0;
        start = 1'b0;
        blk_addr = 12'h0;
        mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) arr[i] = 16'h0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobes", 32'(mem_wr) + 32'(cache_rd_en) + 32'(done), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        #10 rst_n = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // Back-to-back: each run starts in the first IDLE cycle after the previous done.
        for (int v = 0; v < 5; v++)
            run_evict(tbl[v].blk, tbl[v].stall_word, tbl[v].stall_len, 1'b0, 1'b0,
                      tbl[v].exp_done);

        // Start pulses with another block during word 3 and during DONE are ignored.
        run_evict(12'hABC, -1, 0, 1'b0, 1'b1, 17);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_restart", 32'(busy) + 32'(cache_rd_en) + 32'(mem_wr), 32'd0);
        end

        // Asynchronous reset while writing word 5.
        for (int i = 0; i < 8; i++) arr[i] = 16'h2000 + 16'(i);
        mem_ready = 1'b1;
        start = 1'b1;
        blk_addr = 12'hABC;
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (mem_wr && mem_addr[3:1] == 3'd5) break;
            step();
        end
        chk("reached_word5", 32'(mem_addr), 32'h0000ABCA);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mem_wr", 32'(mem_wr), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rd_en", 32'(cache_rd_en), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        step();
        #3 rst_n = 1'b1;
        step();
        chk("post_rst_idle", 32'(busy), 32'd0);
        run_evict(12'h001, -1, 0, 1'b0, 1'b0, 17);

        // Randomized blocks, data and backpressure.
        for (int r = 0; r < 20; r++) begin
            run_evict(12'($urandom), -1, 0, 1'b1, 1'b0, 17);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
